// File: rtl/dvp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// dvp_pkg: pixel/FIFO entry widths, entry layout and packer FSM encoding.
// Rev 1.0
package dvp_pkg;

  localparam int PIX_W        = 16;
  localparam int FIFO_ENTRY_W = PIX_W + 2;

  typedef enum logic [0:0] {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic             sof;
    logic             eol;
  } fifo_entry_t;

  function automatic logic [PIX_W-1:0] join_bytes(
    input logic [7:0] b_first,
    input logic [7:0] b_second,
    input logic       msb_first
  );
    return msb_first ? {b_first, b_second} : {b_second, b_first};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// dvp_sync_fifo: ring-buffer FIFO whose head is held in a register, giving a stable AXI-style output.
// Rev 1.0
module dvp_sync_fifo
  import dvp_pkg::*;
#(
  parameter int WIDTH = FIFO_ENTRY_W,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_drop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             accept;

  assign empty      = (count == '0);
  assign full       = (count == CNT_FULL);
  assign rd_valid   = !empty;
  assign rd_data    = head;
  assign pop        = rd_valid && rd_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign accept     = wr_en && (!full || pop);
  assign wr_drop    = wr_en && !accept;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Head only changes when it is consumed or the FIFO was empty, so it
      // stays stable while the consumer stalls.
      if (pop) begin
        if (count > CNT_W'(1)) begin
          head <= mem[rd_ptr_inc];
        end else if (accept) begin
          head <= wr_data;
        end
      end else if (empty && accept) begin
        head <= wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dvp_pixel_packer.sv
`timescale 1ns/1ps
`default_nettype none
// dvp_pixel_packer: pairs DVP bytes into RGB565 pixels, checks frame geometry, emits AXI4-Stream video.
// Rev 1.0
module dvp_pixel_packer
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic              pclk,
  input  logic              resetn,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic [PIX_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              overflow,
  output logic              frame_err
);

  localparam int               COL_W    = $clog2(H_ACTIVE);
  localparam int               ROW_W    = $clog2(V_ACTIVE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

  state_t           state;
  state_t           state_nxt;
  logic             phase;
  logic             phase_nxt;
  logic             frame_done;
  logic             frame_done_nxt;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] row_nxt;
  logic [7:0]       first_byte;
  logic             load_byte;
  logic             push;
  logic             push_drop;
  logic             geom_err;
  fifo_entry_t      push_entry;
  fifo_entry_t      head_entry;
  logic [FIFO_ENTRY_W-1:0] head_bits;

  always_comb begin
    state_nxt        = state;
    phase_nxt        = phase;
    frame_done_nxt   = frame_done;
    col_nxt          = col;
    row_nxt          = row;
    load_byte        = 1'b0;
    push             = 1'b0;
    geom_err         = 1'b0;
    push_entry.pixel = join_bytes(first_byte, s_axis_tdata, MSB_FIRST);
    push_entry.sof   = (col == '0) && (row == '0);
    push_entry.eol   = (col == COL_LAST);

    if (s_axis_tvalid) begin
      case (state)
        ST_SYNC: begin
          if (s_axis_tlast) begin
            state_nxt      = ST_ACTIVE;
            phase_nxt      = 1'b0;
            frame_done_nxt = 1'b0;
            col_nxt        = '0;
            row_nxt        = '0;
          end
        end
        ST_ACTIVE: begin
          if (frame_done) begin
            // Frame already complete but no tlast arrived: long frame.
            geom_err  = 1'b1;
            state_nxt = ST_SYNC;
          end else if (!phase) begin
            load_byte = 1'b1;
            phase_nxt = 1'b1;
            if (s_axis_tlast) begin
              geom_err  = 1'b1;
              phase_nxt = 1'b0;
              col_nxt   = '0;
              row_nxt   = '0;
            end
          end else begin
            push      = 1'b1;
            phase_nxt = 1'b0;
            if (s_axis_tlast) begin
              geom_err = !((col == COL_LAST) && (row == ROW_LAST));
              col_nxt  = '0;
              row_nxt  = '0;
            end else if (col == COL_LAST) begin
              col_nxt = '0;
              if (row == ROW_LAST) begin
                row_nxt        = '0;
                frame_done_nxt = 1'b1;
              end else begin
                row_nxt = row + ROW_W'(1);
              end
            end else begin
              col_nxt = col + COL_W'(1);
            end
          end
        end
        default: state_nxt = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_SYNC;
      phase      <= 1'b0;
      frame_done <= 1'b0;
      col        <= '0;
      row        <= '0;
      first_byte <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // A pixel lost to a full FIFO abandons the rest of the frame.
      state      <= push_drop ? ST_SYNC : state_nxt;
      phase      <= phase_nxt;
      frame_done <= frame_done_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      frame_err  <= geom_err;
      if (load_byte) begin
        first_byte <= s_axis_tdata;
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  dvp_sync_fifo #(
    .WIDTH (FIFO_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (pclk),
    .rst_n    (resetn),
    .wr_en    (push),
    .wr_data  (push_entry),
    .wr_drop  (push_drop),
    .rd_data  (head_bits),
    .rd_valid (m_axis_tvalid),
    .rd_ready (m_axis_tready)
  );

  assign head_entry   = fifo_entry_t'(head_bits);
  assign m_axis_tdata = head_entry.pixel;
  assign m_axis_tuser = head_entry.sof;
  assign m_axis_tlast = head_entry.eol;

endmodule
`default_nettype wire
